// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy width,
// per-edge priority encoding and payload field layout of a stage bundle.
package pipe_pkg;

    localparam int unsigned PIPE_OCC_W = 2;

    typedef logic [1:0] pipe_pri_t;

    localparam pipe_pri_t PRI_CLR   = 2'd0;
    localparam pipe_pri_t PRI_HOLD  = 2'd1;
    localparam pipe_pri_t PRI_FLUSH = 2'd2;
    localparam pipe_pri_t PRI_RUN   = 2'd3;

    // Field layout of the 256-bit stage bundle (LSB offset / width)
    localparam int unsigned PC_LSB   = 0;
    localparam int unsigned PC_W     = 64;
    localparam int unsigned INS_LSB  = 64;
    localparam int unsigned INS_W    = 32;
    localparam int unsigned DEC_LSB  = 96;
    localparam int unsigned DEC_W    = 64;
    localparam int unsigned ALU_LSB  = 160;
    localparam int unsigned ALU_W    = 64;
    localparam int unsigned CSR_LSB  = 224;
    localparam int unsigned CSR_W    = 28;
    localparam int unsigned PRIV_LSB = 252;
    localparam int unsigned PRIV_W   = 2;
    localparam int unsigned FLAG_LSB = 254;
    localparam int unsigned FLAG_W   = 2;

    // Resolve the control inputs into the single action taken at the next edge
    function automatic pipe_pri_t pipe_pri_sel(input logic clear, input logic hold,
                                               input logic flush);
        if (clear) begin
            return PRI_CLR;
        end else if (hold) begin
            return PRI_HOLD;
        end else if (flush) begin
            return PRI_FLUSH;
        end
        return PRI_RUN;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying one stage bundle. The producer side uses
// master, the consumer side uses slave.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 256
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage entry of a stage: payload register plus valid flag.
// kill empties the entry and zeroes the payload, load captures data,
// drop only invalidates (payload stays as is).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             kill,
    input  logic             drop,
    input  logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [WIDTH-1:0] payload
);
    logic             valid_q;
    logic [WIDTH-1:0] payload_q;

    // Entry state: kill beats load beats drop, otherwise keep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (kill) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load) begin
            valid_q   <= 1'b1;
            payload_q <= data;
        end else if (drop) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid   = valid_q;
    assign payload = payload_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, clear/hold/flush
// controls, optional skid entry (registered upstream ready), occupancy
// report and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W   = 256,
    parameter bit          SKID_EN     = 1'b1,
    parameter bit          ZERO_BUBBLE = 1'b1,
    parameter int unsigned STALL_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  hold,
    input  logic                  flush,
    pipe_stage_skid_if.slave      up,
    pipe_stage_skid_if.master     dn,
    output logic [PIPE_OCC_W-1:0] occupancy,
    output logic [STALL_W-1:0]    stall_cnt
);
    logic                 main_valid, skid_valid;
    logic [PAYLOAD_W-1:0] main_payload, skid_payload, main_data;
    logic                 main_load, main_kill, main_drop;
    logic                 skid_load, skid_kill, skid_valid_next;
    logic                 in_ready, in_fire, out_fire, stall_inc;
    logic                 in_ready_q, in_ready_d;
    logic [STALL_W-1:0]   stall_q;
    pipe_pri_t            pri;

    // Handshake: in_ready_q is low during reset and for one edge after it
    always_comb begin
        if (SKID_EN) begin
            in_ready = in_ready_q & ~hold;
        end else begin
            in_ready = in_ready_q & ~hold & (~main_valid | dn.ready);
        end
        in_fire  = up.valid & in_ready;
        out_fire = main_valid & dn.ready & ~hold;
    end

    // Entry control: decide what each slot does at the next edge
    always_comb begin
        pri             = pipe_pri_sel(clear, hold, flush);
        main_load       = 1'b0;
        main_kill       = 1'b0;
        main_drop       = 1'b0;
        main_data       = up.payload;
        skid_load       = 1'b0;
        skid_kill       = 1'b0;
        skid_valid_next = skid_valid;
        unique case (pri)
            PRI_CLR, PRI_FLUSH: begin
                main_kill       = 1'b1;
                skid_kill       = 1'b1;
                skid_valid_next = 1'b0;
            end
            PRI_HOLD: begin
            end
            PRI_RUN: begin
                if (!main_valid || out_fire) begin
                    // Older skid beat always goes first; in_fire cannot coincide
                    if (skid_valid) begin
                        main_load       = 1'b1;
                        main_data       = skid_payload;
                        skid_kill       = 1'b1;
                        skid_valid_next = 1'b0;
                    end else if (in_fire) begin
                        main_load = 1'b1;
                    end else begin
                        main_drop = 1'b1;
                    end
                end else if (in_fire) begin
                    skid_load       = 1'b1;
                    skid_valid_next = 1'b1;
                end
            end
            default: begin
            end
        endcase
        in_ready_d = SKID_EN ? ~skid_valid_next : 1'b1;
    end

    // Registered upstream ready (tracks skid emptiness when the skid exists)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign stall_inc = (main_valid & ~dn.ready) | hold;

    // Saturating stall counter, only cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    pipe_slot #(
        .WIDTH (PAYLOAD_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .kill    (main_kill),
        .drop    (main_drop),
        .data    (main_data),
        .valid   (main_valid),
        .payload (main_payload)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(
            .WIDTH (PAYLOAD_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load),
            .kill    (skid_kill),
            .drop    (1'b0),
            .data    (up.payload),
            .valid   (skid_valid),
            .payload (skid_payload)
        );
    end else begin : g_no_skid
        assign skid_valid   = 1'b0;
        assign skid_payload = '0;
    end

    assign up.ready    = in_ready;
    assign dn.valid    = main_valid;
    assign dn.payload  = (ZERO_BUBBLE && !main_valid) ? '0 : main_payload;
    assign occupancy   = PIPE_OCC_W'(main_valid) + PIPE_OCC_W'(skid_valid);
    assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a directed vector table on a skid instance,
// then random traffic on a skid instance and a no-skid instance checked
// against a two-deep FIFO reference model, then stall saturation and
// asynchronous reset.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic clk, rst;
    logic clear_a, hold_a, flush_a, clear_b, hold_b, flush_b;
    logic [1:0]  occ_a, occ_b;
    logic [15:0] st_a;
    logic [3:0]  st_b;

    pipe_stage_skid_if #(.PAYLOAD_W(32)) up_a ();
    pipe_stage_skid_if #(.PAYLOAD_W(32)) dn_a ();
    pipe_stage_skid_if #(.PAYLOAD_W(32)) up_b ();
    pipe_stage_skid_if #(.PAYLOAD_W(32)) dn_b ();

    pipe_stage_skid #(
        .PAYLOAD_W (32), .SKID_EN (1'b1), .ZERO_BUBBLE (1'b1), .STALL_W (16)
    ) dut_a (
        .clk (clk), .rst (rst), .clear (clear_a), .hold (hold_a), .flush (flush_a),
        .up (up_a), .dn (dn_a), .occupancy (occ_a), .stall_cnt (st_a)
    );

    pipe_stage_skid #(
        .PAYLOAD_W (32), .SKID_EN (1'b0), .ZERO_BUBBLE (1'b0), .STALL_W (4)
    ) dut_b (
        .clk (clk), .rst (rst), .clear (clear_b), .hold (hold_b), .flush (flush_b),
        .up (up_b), .dn (dn_b), .occupancy (occ_b), .stall_cnt (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        clr, hold, fl, iv;
        logic [31:0] ip;
        logic        ordy;
    } stim_t;

    typedef struct packed {
        logic        clr, hold, fl, iv;
        logic [31:0] ip;
        logic        ordy;
        logic        e_irdy, e_ov;
        logic [31:0] e_op;
        logic [1:0]  e_occ;
        logic [15:0] e_st;
    } vec_t;

    int n_tests, n_fail;

    // Reference model: d=0 skid instance, d=1 no-skid instance
    int          m_cnt   [2];
    logic [31:0] m_ent   [2][2];
    logic [31:0] m_last  [2];
    int          m_stall [2];
    bit          m_rel   [2];
    bit          m_skid  [2] = '{1'b1, 1'b0};
    bit          m_zb    [2] = '{1'b1, 1'b0};
    int          m_smax  [2] = '{65535, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]   = 0;
            m_last[d]  = '0;
            m_stall[d] = 0;
            m_rel[d]   = 1'b0;
        end
    endtask

    // Compare one instance against the model, then advance the model one edge
    task automatic model_cycle(input int d, input stim_t s, input logic irdy, input logic ov,
                               input logic [31:0] op, input logic [1:0] occ,
                               input logic [31:0] st);
        string p;
        logic  e_irdy;
        bit    inf, outf;
        p = (d == 0) ? "A" : "B";
        e_irdy = m_rel[d] && !s.hold && (m_skid[d] ? (m_cnt[d] < 2) : (m_cnt[d] == 0 || s.ordy));
        check({p, ".in_ready"}, 32'(irdy), 32'(e_irdy));
        check({p, ".out_valid"}, 32'(ov), 32'(m_cnt[d] > 0));
        check({p, ".out_payload"}, op,
              (m_cnt[d] > 0) ? m_ent[d][0] : (m_zb[d] ? 32'h0 : m_last[d]));
        check({p, ".occupancy"}, 32'(occ), 32'(m_cnt[d]));
        check({p, ".stall_cnt"}, st, 32'(m_stall[d]));
        inf  = s.iv && e_irdy;
        outf = (m_cnt[d] > 0) && s.ordy && !s.hold;
        if (((m_cnt[d] > 0 && !s.ordy) || s.hold) && m_stall[d] < m_smax[d]) m_stall[d]++;
        if (s.clr || (!s.hold && s.fl)) begin
            m_cnt[d]  = 0;
            m_last[d] = '0;
        end else if (!s.hold) begin
            if (outf) begin
                m_ent[d][0] = m_ent[d][1];
                m_cnt[d]--;
            end
            if (inf) begin
                m_ent[d][m_cnt[d]] = s.ip;
                m_cnt[d]++;
            end
            if (m_cnt[d] > 0) m_last[d] = m_ent[d][0];
        end
        m_rel[d] = 1'b1;
    endtask

    task automatic run_cycle(input stim_t sa, input stim_t sb);
        clear_a = sa.clr; hold_a = sa.hold; flush_a = sa.fl;
        up_a.valid = sa.iv; up_a.payload = sa.ip; dn_a.ready = sa.ordy;
        clear_b = sb.clr; hold_b = sb.hold; flush_b = sb.fl;
        up_b.valid = sb.iv; up_b.payload = sb.ip; dn_b.ready = sb.ordy;
        #1;
        model_cycle(0, sa, up_a.ready, dn_a.valid, dn_a.payload, occ_a, 32'(st_a));
        model_cycle(1, sb, up_b.ready, dn_b.valid, dn_b.payload, occ_b, 32'(st_b));
        @(negedge clk);
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.clr  = ($urandom_range(0, 31) == 0);
        s.hold = ($urandom_range(0, 7) == 0);
        s.fl   = ($urandom_range(0, 15) == 0);
        s.iv   = ($urandom_range(0, 3) != 0);
        s.ip   = $urandom;
        s.ordy = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic check_zero(input string p, input logic irdy, input logic ov,
                              input logic [31:0] op, input logic [1:0] occ,
                              input logic [31:0] st);
        check({p, ".in_ready"}, 32'(irdy), 32'h0);
        check({p, ".out_valid"}, 32'(ov), 32'h0);
        check({p, ".out_payload"}, op, 32'h0);
        check({p, ".occupancy"}, 32'(occ), 32'h0);
        check({p, ".stall_cnt"}, st, 32'h0);
    endtask

    vec_t  tbl [28];
    stim_t idle, sb;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle    = '0;
        rst     = 1'b0;
        clear_a = 0; hold_a = 0; flush_a = 0; up_a.valid = 0; up_a.payload = '0; dn_a.ready = 0;
        clear_b = 0; hold_b = 0; flush_b = 0; up_b.valid = 0; up_b.payload = '0; dn_b.ready = 0;

        //            clr hld fl iv  payload     ordy irdy ov  out_payload occ stall
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,32'hA1,1'b1, 1'b1,1'b0,32'h00,2'd0,16'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,32'hA2,1'b1, 1'b1,1'b1,32'hA1,2'd1,16'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,32'hA3,1'b1, 1'b1,1'b1,32'hA2,2'd1,16'd0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,32'hA4,1'b1, 1'b1,1'b1,32'hA3,2'd1,16'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b1,32'hA4,2'd1,16'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,32'hB1,1'b1, 1'b1,1'b0,32'h00,2'd0,16'd0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,32'hB2,1'b0, 1'b1,1'b1,32'hB1,2'd1,16'd0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b0, 1'b0,1'b1,32'hB1,2'd2,16'd1};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b0,1'b1,32'hB1,2'd2,16'd2};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b1,32'hB2,2'd1,16'd2};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,32'hC1,1'b1, 1'b1,1'b0,32'h00,2'd0,16'd2};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1,32'hC9,1'b1, 1'b0,1'b1,32'hC1,2'd1,16'd2};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b1,32'hC9,1'b1, 1'b0,1'b1,32'hC1,2'd1,16'd3};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b1,32'hC9,1'b1, 1'b0,1'b1,32'hC1,2'd1,16'd4};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b1,32'hC1,2'd1,16'd5};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1,32'hD1,1'b0, 1'b1,1'b0,32'h00,2'd0,16'd5};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b1,32'hD2,1'b0, 1'b1,1'b1,32'hD1,2'd1,16'd5};
        tbl[17] = '{1'b0,1'b0,1'b1,1'b1,32'hD3,1'b0, 1'b0,1'b1,32'hD1,2'd2,16'd6};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b0,32'h00,2'd0,16'd7};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b1,32'hE1,1'b0, 1'b1,1'b0,32'h00,2'd0,16'd7};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b1,32'hE2,1'b0, 1'b1,1'b1,32'hE1,2'd1,16'd7};
        tbl[21] = '{1'b1,1'b1,1'b1,1'b1,32'hE3,1'b0, 1'b0,1'b1,32'hE1,2'd2,16'd8};
        tbl[22] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b0, 1'b1,1'b0,32'h00,2'd0,16'd9};
        tbl[23] = '{1'b0,1'b0,1'b0,1'b1,32'hF1,1'b0, 1'b1,1'b0,32'h00,2'd0,16'd9};
        tbl[24] = '{1'b0,1'b1,1'b1,1'b1,32'hF2,1'b0, 1'b0,1'b1,32'hF1,2'd1,16'd9};
        tbl[25] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b0, 1'b1,1'b1,32'hF1,2'd1,16'd10};
        tbl[26] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b1,32'hF1,2'd1,16'd11};
        tbl[27] = '{1'b0,1'b0,1'b0,1'b0,32'h00,1'b1, 1'b1,1'b0,32'h00,2'd0,16'd11};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_zero("rst.A", up_a.ready, dn_a.valid, dn_a.payload, occ_a, 32'(st_a));
        check_zero("rst.B", up_b.ready, dn_b.valid, dn_b.payload, occ_b, 32'(st_b));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors on the skid instance
        for (int i = 0; i < 28; i++) begin
            clear_a = tbl[i].clr; hold_a = tbl[i].hold; flush_a = tbl[i].fl;
            up_a.valid = tbl[i].iv; up_a.payload = tbl[i].ip; dn_a.ready = tbl[i].ordy;
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(up_a.ready), 32'(tbl[i].e_irdy));
            check($sformatf("vec%0d.out_valid", i), 32'(dn_a.valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d.out_payload", i), dn_a.payload, tbl[i].e_op);
            check($sformatf("vec%0d.occupancy", i), 32'(occ_a), 32'(tbl[i].e_occ));
            check($sformatf("vec%0d.stall_cnt", i), 32'(st_a), 32'(tbl[i].e_st));
            @(negedge clk);
        end

        // Random traffic on both instances against the model
        clear_a = 0; hold_a = 0; flush_a = 0; up_a.valid = 0; dn_a.ready = 0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 600; i++) begin
            run_cycle(rnd_stim(), rnd_stim());
        end

        // Stall saturation on the 4-bit counter
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_cycle(idle, idle);
        sb      = idle;
        sb.iv   = 1'b1;
        sb.ip   = 32'h66;
        run_cycle(idle, sb);
        for (int i = 0; i < 20; i++) begin
            run_cycle(idle, idle);
        end
        check("sat.stall_cnt", 32'(st_b), 32'd15);
        check("sat.out_payload", dn_b.payload, 32'h66);

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        check_zero("arst.A", up_a.ready, dn_a.valid, dn_a.payload, occ_a, 32'(st_a));
        check_zero("arst.B", up_b.ready, dn_b.valid, dn_b.payload, occ_b, 32'(st_b));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
